// File: rtl/trap_sequencer_pkg.sv
// trap_sequencer_pkg: CSR addresses, mcause codes, mstatus bit positions and FSM states
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package trap_sequencer_pkg;
    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
    localparam logic [3:0] CAUSE_M_TIMER = 4'd7;
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_EPC,
        ST_W_CAUSE,
        ST_W_STATUS,
        ST_RD_TVEC,
        ST_W_STATUS_RET,
        ST_RD_EPC,
        ST_REDIRECT
    } state_t;
endpackage

// File: rtl/trap_sequencer_csr_port_mux.sv
// trap_sequencer_csr_port_mux: CSR port owned by the pipeline when idle, by the sequencer otherwise
module trap_sequencer_csr_port_mux
    import trap_sequencer_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic          rst,
    input  logic          idle,
    input  logic          pipe_csr_wren,
    input  logic [11:0]   pipe_csr_waddr,
    input  logic [DW-1:0] pipe_csr_wdata,
    input  logic [11:0]   pipe_csr_raddr,
    output logic [DW-1:0] pipe_csr_rdata,
    input  logic          fsm_wren,
    input  logic [11:0]   fsm_waddr,
    input  logic [DW-1:0] fsm_wdata,
    input  logic [11:0]   fsm_raddr,
    output logic          csr_wren,
    output logic [11:0]   csr_waddr,
    output logic [DW-1:0] csr_wdata,
    output logic [11:0]   csr_raddr,
    input  logic [DW-1:0] csr_rdata
);
    // select port owner; reset suppresses any write so an aborted sequence leaves the CSR file untouched
    always_comb begin
        csr_wren       = !rst && (idle ? pipe_csr_wren : fsm_wren);
        csr_waddr      = idle ? pipe_csr_waddr : fsm_waddr;
        csr_wdata      = idle ? pipe_csr_wdata : fsm_wdata;
        csr_raddr      = idle ? pipe_csr_raddr : fsm_raddr;
        pipe_csr_rdata = idle ? csr_rdata : '0;
    end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: M-mode trap entry / mret sequencing over the CSR port; TRAP_IRQ_EN adds the timer IRQ path
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int          DW          = DATA_WIDTH,
    parameter logic [31:0] MSTATUS_RST = 32'h1800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          exc_valid,
    input  logic [3:0]    exc_cause,
    input  logic [DW-1:0] cur_pc,
    input  logic          mret_valid,
`ifdef TRAP_IRQ_EN
    input  logic          irq_timer,
`endif
    input  logic          pipe_csr_wren,
    input  logic [11:0]   pipe_csr_waddr,
    input  logic [DW-1:0] pipe_csr_wdata,
    input  logic [11:0]   pipe_csr_raddr,
    output logic [DW-1:0] pipe_csr_rdata,
    output logic          csr_wren,
    output logic [11:0]   csr_waddr,
    output logic [DW-1:0] csr_wdata,
    output logic [11:0]   csr_raddr,
    input  logic [DW-1:0] csr_rdata,
    output logic          busy,
    output logic          redirect_valid,
    output logic [DW-1:0] redirect_pc,
    output logic          trap_ack
);
    localparam logic [DW-1:0] IRQ_CAUSE = {1'b1, {(DW-5){1'b0}}, CAUSE_M_TIMER};

    state_t        state_q, state_d;
    logic [DW-1:0] pc_q, cause_q, status_trap, status_ret;
    logic          mie_shadow, irq_req, idle;
    logic          fsm_wren;
    logic [11:0]   fsm_waddr, fsm_raddr;
    logic [DW-1:0] fsm_wdata;

`ifdef TRAP_IRQ_EN
    assign irq_req = irq_timer & mie_shadow;
`else
    assign irq_req = 1'b0 & mie_shadow;
`endif

    assign idle = state_q == ST_IDLE;

    // state register
    always_ff @(posedge clk) begin
        state_q <= rst ? ST_IDLE : state_d;
    end

    // next state: exception beats mret beats interrupt; trap path is 5 cycles, mret path 3
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:         state_d = exc_valid ? ST_W_EPC : mret_valid ? ST_W_STATUS_RET : irq_req ? ST_W_EPC : ST_IDLE;
            ST_W_EPC:        state_d = ST_W_CAUSE;
            ST_W_CAUSE:      state_d = ST_W_STATUS;
            ST_W_STATUS:     state_d = ST_RD_TVEC;
            ST_RD_TVEC:      state_d = ST_REDIRECT;
            ST_W_STATUS_RET: state_d = ST_RD_EPC;
            ST_RD_EPC:       state_d = ST_REDIRECT;
            default:         state_d = ST_IDLE;
        endcase
    end

    // sequencer-side CSR port and the mstatus read-modify-write images
    always_comb begin
        fsm_wren = 1'b0;
        fsm_waddr = '0;
        fsm_wdata = '0;
        fsm_raddr = '0;
        status_trap = csr_rdata;
        status_trap[MPIE_BIT] = csr_rdata[MIE_BIT];
        status_trap[MIE_BIT] = 1'b0;
        status_trap[MPP_HI:MPP_LO] = 2'b11;
        status_ret = csr_rdata;
        status_ret[MIE_BIT] = csr_rdata[MPIE_BIT];
        status_ret[MPIE_BIT] = 1'b1;
        status_ret[MPP_HI:MPP_LO] = 2'b11;
        case (state_q)
            ST_W_EPC: begin
                fsm_wren = 1'b1;
                fsm_waddr = CSR_MEPC;
                fsm_wdata = pc_q;
            end
            ST_W_CAUSE: begin
                fsm_wren = 1'b1;
                fsm_waddr = CSR_MCAUSE;
                fsm_wdata = cause_q;
            end
            ST_W_STATUS: begin
                fsm_wren = 1'b1;
                fsm_waddr = CSR_MSTATUS;
                fsm_wdata = status_trap;
                fsm_raddr = CSR_MSTATUS;
            end
            ST_W_STATUS_RET: begin
                fsm_wren = 1'b1;
                fsm_waddr = CSR_MSTATUS;
                fsm_wdata = status_ret;
                fsm_raddr = CSR_MSTATUS;
            end
            ST_RD_TVEC: fsm_raddr = CSR_MTVEC;
            ST_RD_EPC:  fsm_raddr = CSR_MEPC;
            default: ;
        endcase
    end

    // status outputs; reset in the redirect cycle swallows the pulse
    always_comb begin
        busy = !idle;
        redirect_valid = !rst && state_q == ST_REDIRECT;
        trap_ack = !rst && state_q == ST_REDIRECT;
    end

    // request capture while idle, redirect target latch, MIE shadow from every mstatus write
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
            cause_q <= '0;
            redirect_pc <= '0;
            mie_shadow <= MSTATUS_RST[MIE_BIT];
        end else begin
            if (idle) begin
                pc_q <= cur_pc;
                cause_q <= exc_valid ? {{(DW-4){1'b0}}, exc_cause} : IRQ_CAUSE;
            end
            if (state_q == ST_RD_TVEC)
                redirect_pc <= {csr_rdata[DW-1:2], 2'b00};
            if (state_q == ST_RD_EPC)
                redirect_pc <= csr_rdata;
            if (csr_wren && csr_waddr == CSR_MSTATUS)
                mie_shadow <= csr_wdata[MIE_BIT];
        end
    end

    trap_sequencer_csr_port_mux #(.DW(DW)) u_mux (
        .rst            (rst),
        .idle           (idle),
        .pipe_csr_wren  (pipe_csr_wren),
        .pipe_csr_waddr (pipe_csr_waddr),
        .pipe_csr_wdata (pipe_csr_wdata),
        .pipe_csr_raddr (pipe_csr_raddr),
        .pipe_csr_rdata (pipe_csr_rdata),
        .fsm_wren       (fsm_wren),
        .fsm_waddr      (fsm_waddr),
        .fsm_wdata      (fsm_wdata),
        .fsm_raddr      (fsm_raddr),
        .csr_wren       (csr_wren),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata)
    );
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scoreboard bench for trap_sequencer with a behavioural CSR file; TRAP_IRQ_EN adds the IRQ case
module tb_trap_sequencer;
    logic        clk, rst;
    logic        exc_valid, mret_valid;
    logic [3:0]  exc_cause;
    logic [31:0] cur_pc;
`ifdef TRAP_IRQ_EN
    logic        irq_timer;
`endif
    logic        pipe_csr_wren;
    logic [11:0] pipe_csr_waddr, pipe_csr_raddr;
    logic [31:0] pipe_csr_wdata, pipe_csr_rdata;
    logic        csr_wren;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        busy, redirect_valid, trap_ack;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] csr_mem [4096];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    trap_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .cur_pc         (cur_pc),
        .mret_valid     (mret_valid),
`ifdef TRAP_IRQ_EN
        .irq_timer      (irq_timer),
`endif
        .pipe_csr_wren  (pipe_csr_wren),
        .pipe_csr_waddr (pipe_csr_waddr),
        .pipe_csr_wdata (pipe_csr_wdata),
        .pipe_csr_raddr (pipe_csr_raddr),
        .pipe_csr_rdata (pipe_csr_rdata),
        .csr_wren       (csr_wren),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_ack       (trap_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural CSR file: synchronous write, combinational read
    always @(posedge clk) if (csr_wren) csr_mem[csr_waddr] <= csr_wdata;
    assign csr_rdata = csr_mem[csr_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard: every redirect pulse must match the oldest expected target and cycle
    always @(negedge clk) begin
        if (redirect_valid || trap_ack)
            check("ack_eq_redirect", 32'(trap_ack), 32'(redirect_valid));
        if (redirect_valid) begin
            check("redirect_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("redirect_pc", redirect_pc, e.pc);
                check("redirect_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic pipe_wr(input logic [11:0] a, input logic [31:0] d);
        pipe_csr_wren = 1'b1;
        pipe_csr_waddr = a;
        pipe_csr_wdata = d;
        #1 check("pt_write", csr_wren ? csr_wdata : 32'hdead_beef, d);
        @(negedge clk);
        pipe_csr_wren = 1'b0;
    endtask

    task automatic pipe_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        pipe_csr_raddr = a;
        #1 check(tag, pipe_csr_rdata, exp);
        @(negedge clk);
    endtask

    // wait for trap_ack (bounded), counting busy cycles; poke tries a pipeline mtvec write while busy
    task automatic wait_ack(input int exp_busy, input bit poke);
        int n = 0;
        int i = 0;
        do begin
            @(negedge clk);
            n += int'(busy);
            if (poke && i == 0) begin
                pipe_csr_wren = 1'b1;
                pipe_csr_waddr = 12'h305;
                pipe_csr_wdata = 32'h8000_0200;
                pipe_csr_raddr = 12'h305;
                #1 check("busy_rdata_zero", pipe_csr_rdata, 32'h0);
            end
            i++;
        end while (!trap_ack && i < 20);
        check("ack_seen", 32'(trap_ack), 1);
        check("busy_cycles", 32'(n), 32'(exp_busy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        exc_valid = 1'b0;
        mret_valid = 1'b0;
        exc_cause = 4'd0;
        cur_pc = 32'h0;
`ifdef TRAP_IRQ_EN
        irq_timer = 1'b0;
`endif
        pipe_csr_wren = 1'b0;
        pipe_csr_waddr = 12'h0;
        pipe_csr_wdata = 32'h0;
        pipe_csr_raddr = 12'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_redirect_valid", 32'(redirect_valid), 0);
        check("rst_trap_ack", 32'(trap_ack), 0);
        check("rst_csr_wren", 32'(csr_wren), 0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        pipe_wr(12'h305, 32'h8000_0100);
        pipe_wr(12'h300, 32'h0000_1808);
        pipe_rd("pt_read_mtvec", 12'h305, 32'h8000_0100);

        // ecall, with a pipeline mtvec write attempted while busy
        cur_pc = 32'h8000_0040;
        exc_cause = 4'd11;
        exc_valid = 1'b1;
        sb.push_back('{pc: 32'h8000_0100, cyc: cyc + 5});
        wait_ack(5, 1'b1);
        exc_valid = 1'b0;
        pipe_csr_wren = 1'b0;
        @(negedge clk);
        check("ecall_mepc", csr_mem[12'h341], 32'h8000_0040);
        check("ecall_mcause", csr_mem[12'h342], 32'd11);
        check("ecall_mstatus", csr_mem[12'h300], 32'h0000_1880);
        pipe_rd("busy_write_dropped", 12'h305, 32'h8000_0100);

        // mret back to mepc
        mret_valid = 1'b1;
        sb.push_back('{pc: 32'h8000_0040, cyc: cyc + 3});
        wait_ack(3, 1'b0);
        mret_valid = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(trap_ack), 0);
        check("mret_mstatus", csr_mem[12'h300], 32'h0000_1888);

        // exception and mret together: trap first, held mret afterwards
        cur_pc = 32'h8000_0080;
        exc_cause = 4'd3;
        exc_valid = 1'b1;
        mret_valid = 1'b1;
        sb.push_back('{pc: 32'h8000_0100, cyc: cyc + 5});
        wait_ack(5, 1'b0);
        exc_valid = 1'b0;
        check("both_mcause", csr_mem[12'h342], 32'd3);
        check("both_mepc", csr_mem[12'h341], 32'h8000_0080);
        check("both_mstatus", csr_mem[12'h300], 32'h0000_1880);
        sb.push_back('{pc: 32'h8000_0080, cyc: cyc + 4});
        wait_ack(3, 1'b0);
        mret_valid = 1'b0;
        @(negedge clk);
        check("both_mret_mstatus", csr_mem[12'h300], 32'h0000_1888);

        // new mtvec from the pipeline; low mode bits are masked off the vector
        pipe_wr(12'h305, 32'h8000_0203);
        pipe_rd("pt_read_new_mtvec", 12'h305, 32'h8000_0203);
        cur_pc = 32'h8000_0044;
        exc_cause = 4'd11;
        exc_valid = 1'b1;
        sb.push_back('{pc: 32'h8000_0200, cyc: cyc + 5});
        wait_ack(5, 1'b0);
        exc_valid = 1'b0;
        @(negedge clk);
        check("tvec_mepc", csr_mem[12'h341], 32'h8000_0044);

        // reset in the W_STATUS cycle aborts with no redirect and no mstatus write
        cur_pc = 32'h8000_00c0;
        exc_cause = 4'd2;
        exc_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        exc_valid = 1'b0;
        #1 check("abort_wren_blocked", 32'(csr_wren), 0);
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_redirect_valid", 32'(redirect_valid), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_idle_after", 32'(busy), 0);
        check("abort_mstatus", csr_mem[12'h300], 32'h0000_1880);
        check("abort_redirect_pc", redirect_pc, 32'h0);

`ifdef TRAP_IRQ_EN
        // masked timer IRQ is ignored until MIE is set through the pipeline
        cur_pc = 32'h8000_0100;
        irq_timer = 1'b1;
        repeat (6) @(negedge clk);
        check("irq_masked", 32'(busy), 0);
        sb.push_back('{pc: 32'h8000_0200, cyc: cyc + 6});
        pipe_wr(12'h300, 32'h0000_1808);
        wait_ack(5, 1'b0);
        irq_timer = 1'b0;
        @(negedge clk);
        check("irq_mcause", csr_mem[12'h342], 32'h8000_0007);
        check("irq_mepc", csr_mem[12'h341], 32'h8000_0100);
        check("irq_mstatus", csr_mem[12'h300], 32'h0000_1880);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
